// File: rtl/pipeline_debug_controller.sv
// UART-driven sequencing controller for the 5-stage MIPS pipeline: loads program
// words into instruction memory, then runs or single-steps the pipeline via halt.
module pipeline_debug_controller #(
    parameter int unsigned  INST_MEM_WORDS = 64,
    parameter logic [7:0]   CMD_LOAD       = 8'h4C,
    parameter logic [7:0]   CMD_RUN        = 8'h43,
    parameter logic [7:0]   CMD_STEP       = 8'h53,
    parameter logic [7:0]   CMD_NEXT       = 8'h4E,
    parameter logic [31:0]  HALT_WORD      = 32'hFFFFFFFF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_data,
    input  logic        i_tx_done,
    input  logic        i_program_end,
    output logic        o_tx_start,
    output logic [7:0]  o_tx_data,
    output logic        o_halt,
    output logic        o_pipeline_reset,
    output logic        o_write_instruction_flag,
    output logic [31:0] o_instruction_to_write,
    output logic [31:0] o_address_to_write_inst,
    output logic        o_busy
);

    localparam logic [7:0]  ACK        = 8'h06;
    localparam logic [7:0]  NAK        = 8'h15;
    localparam logic [31:0] ADDR_LIMIT = 32'(INST_MEM_WORDS * 4);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, STEP, SEND, WAIT_TX} state_t;

    state_t      state;
    state_t      ret_state;
    logic [31:0] addr;
    logic [1:0]  byte_cnt;
    logic [23:0] word_buf;

    // Handshakes: i_rx_valid and i_tx_done are single-cycle strobes with no
    // back-pressure; o_tx_start is a single-cycle request and o_tx_data stays
    // stable from that cycle until i_tx_done is seen in WAIT_TX.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state                    <= IDLE;
            ret_state                <= IDLE;
            addr                     <= '0;
            byte_cnt                 <= '0;
            word_buf                 <= '0;
            o_tx_start               <= 1'b0;
            o_tx_data                <= '0;
            o_halt                   <= 1'b1;
            o_pipeline_reset         <= 1'b0;
            o_write_instruction_flag <= 1'b0;
            o_instruction_to_write   <= '0;
            o_address_to_write_inst  <= '0;
            o_busy                   <= 1'b0;
        end else begin
            o_pipeline_reset         <= 1'b0;
            o_write_instruction_flag <= 1'b0;
            o_tx_start               <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_rx_valid) begin
                        o_busy <= 1'b1;
                        if (i_rx_data == CMD_LOAD) begin
                            state            <= LOAD;
                            o_pipeline_reset <= 1'b1;
                            addr             <= '0;
                            byte_cnt         <= '0;
                        end else if (i_rx_data == CMD_RUN) begin
                            state  <= RUN;
                            o_halt <= 1'b0;
                        end else if (i_rx_data == CMD_STEP) begin
                            state <= STEP;
                        end else begin
                            state      <= SEND;
                            o_tx_start <= 1'b1;
                            o_tx_data  <= NAK;
                            ret_state  <= IDLE;
                        end
                    end
                end
                LOAD: begin
                    // The end-of-load decision is taken in the write cycle itself,
                    // so a byte arriving alongside a non-final write is still kept.
                    if (o_write_instruction_flag &&
                        (o_instruction_to_write == HALT_WORD || addr == ADDR_LIMIT)) begin
                        state      <= SEND;
                        o_tx_start <= 1'b1;
                        o_tx_data  <= (o_instruction_to_write == HALT_WORD) ? ACK : NAK;
                        ret_state  <= IDLE;
                    end else if (i_rx_valid) begin
                        if (byte_cnt == 2'd3) begin
                            o_write_instruction_flag <= 1'b1;
                            o_instruction_to_write   <= {i_rx_data, word_buf};
                            o_address_to_write_inst  <= addr;
                            addr                     <= addr + 32'd4;
                            byte_cnt                 <= '0;
                        end else begin
                            word_buf[{byte_cnt, 3'b000} +: 8] <= i_rx_data;
                            byte_cnt                          <= byte_cnt + 2'd1;
                        end
                    end
                end
                RUN: begin
                    if (i_program_end) begin
                        o_halt     <= 1'b1;
                        state      <= SEND;
                        o_tx_start <= 1'b1;
                        o_tx_data  <= ACK;
                        ret_state  <= IDLE;
                    end
                end
                STEP: begin
                    // o_halt low inside STEP marks the single released cycle.
                    if (!o_halt || i_program_end) begin
                        o_halt     <= 1'b1;
                        state      <= SEND;
                        o_tx_start <= 1'b1;
                        o_tx_data  <= ACK;
                        ret_state  <= i_program_end ? IDLE : STEP;
                    end else if (i_rx_valid && i_rx_data == CMD_NEXT) begin
                        o_halt <= 1'b0;
                    end
                end
                SEND: begin
                    state <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (i_tx_done) begin
                        state     <= ret_state;
                        o_busy    <= (ret_state != IDLE);
                        o_tx_data <= '0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/pipeline_debug_controller.md
Name: pipeline_debug_controller

Overview:
Sequencing controller for the 5-stage MIPS pipeline. It takes command and data bytes from the UART receiver and loads program words into instruction memory through the pipeline's instruction-write port. It then runs the pipeline in continuous or single-step mode by driving halt, and reports completion to the UART transmitter with ACK/NAK bytes.

Parameters:
INST_MEM_WORDS, 64, instruction memory depth in 32-bit words; the load address range is 0 to INST_MEM_WORDS*4-4.
CMD_LOAD, 8'h4C, command byte that starts program load.
CMD_RUN, 8'h43, command byte for continuous run.
CMD_STEP, 8'h53, command byte that enters step mode.
CMD_NEXT, 8'h4E, command byte that advances one cycle in step mode.
HALT_WORD, 32'hFFFFFFFF, end-of-program instruction word.

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous, active-high reset
i_rx_valid  in  1  one-cycle strobe: i_rx_data holds a received byte
i_rx_data  in  8  received byte
i_tx_done  in  1  one-cycle strobe: transmitter finished the current byte
i_program_end  in  1  pipeline has retired HALT_WORD (level)
o_tx_start  out  1  one-cycle request to send o_tx_data
o_tx_data  out  8  byte to transmit (ACK 8'h06 / NAK 8'h15)
o_halt  out  1  freezes all pipeline stages when high
o_pipeline_reset  out  1  one-cycle synchronous-style reset pulse to the pipeline
o_write_instruction_flag  out  1  one-cycle write strobe to instruction memory
o_instruction_to_write  out  32  word to write
o_address_to_write_inst  out  32  byte address of the word (multiple of 4)
o_busy  out  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock (i_clk); i_reset is asynchronous and active-high.
- All outputs are registered. Reset values: o_halt=1; every other output is 0; state=IDLE.
- States: IDLE, LOAD, RUN, STEP, SEND, WAIT_TX.
- IDLE:
  - CMD_LOAD -> LOAD. Same edge: o_pipeline_reset=1 for 1 cycle, address counter=0, byte counter=0.
  - CMD_RUN -> RUN, o_halt=0.
  - CMD_STEP -> STEP, o_halt stays 1.
  - Any other byte (including CMD_NEXT) -> SEND with NAK.
- LOAD:
  - Bytes arrive little-endian: the 1st byte is bits [7:0], the 4th is [31:24].
  - On the 4th byte, next cycle: o_write_instruction_flag=1 for exactly 1 cycle, o_instruction_to_write=word, o_address_to_write_inst=address counter. Address counter then +4; byte counter wraps to 0.
  - The FSM stays in LOAD during the write cycle, so a byte arriving in that cycle is accepted and no byte is lost.
  - Written word == HALT_WORD -> SEND with ACK. HALT_WORD is itself written.
  - Address counter reaching INST_MEM_WORDS*4 without HALT_WORD -> SEND with NAK; no further writes.
  - A partial word (<4 bytes) is never written.
- RUN:
  - o_halt=0 until i_program_end=1 is sampled; then o_halt=1 from the next cycle -> SEND with ACK.
  - i_rx_valid is ignored in RUN.
- STEP:
  - o_halt=1.
  - CMD_NEXT: o_halt=0 for exactly 1 cycle, then 1 again -> SEND with ACK, returning to STEP afterwards.
  - i_program_end=1 sampled in STEP, or after a step -> SEND with ACK, returning to IDLE.
  - If both apply in the same cycle, the program-end path wins.
  - Other bytes in STEP are ignored.
- SEND: o_tx_start=1 for 1 cycle with o_tx_data valid -> WAIT_TX. o_tx_data holds until i_tx_done.
- WAIT_TX: i_tx_done -> return state (IDLE, or STEP for a non-final step). i_rx_valid is ignored in SEND and WAIT_TX.
- Reset asserted mid-operation: immediate return to reset values. An in-flight write strobe is dropped, and a partial word is discarded.
- o_busy = (state != IDLE).

Test Plan:
1. Reset -> o_halt=1, o_busy=0, all strobes 0. Then 'L' + bytes 78 56 34 12 + FF FF FF FF -> o_pipeline_reset pulse; write 32'h12345678 @0; write 32'hFFFFFFFF @4; o_tx_start with 8'h06.
2. INST_MEM_WORDS=2, load 3 non-halt words -> writes @0 and @4 only, then NAK 8'h15, state IDLE.
3. 'C' -> o_halt=0 for N cycles; raise i_program_end -> o_halt=1 next cycle; ACK sent; after i_tx_done o_busy=0.
4. 'S', then 'N' three times, i_tx_done after each -> exactly three single-cycle o_halt=0 windows and three ACKs; o_halt=1 between steps. Then 'N' with i_program_end=1 -> ACK, return to IDLE.
5. Idle byte 8'h4E and byte 8'h7A -> NAK each; no halt or write activity.
6. Assert i_reset after 2 bytes of a load word and while o_halt=0 in RUN -> outputs return to reset values that cycle. A fresh 'L' load then starts at address 0 with no stale bytes.
